seq_scan_controller: RTL
========================

# seq_scan_controller

Word-level controller for the team's serial 1-1-0-1 detector, `fsm_sequence`. It accepts a parallel word on a valid/ready handshake and shifts it MSB-first into the detector, one bit per clock. It collects every match the detector reports and returns a per-word result set plus a running total. It sits between a parallel producer (register file or bus slave) and the bit-serial detector, and is the only block that drives the detector's input and reset.

## Interface
- `WIDTH`, 8: bits per scanned word; must be ≥ 4.
- `TOTAL_W`, 16: width of the running match total.
- Derived widths:
  - `CW = $clog2(WIDTH+1)`
  - `PW = $clog2(WIDTH)`
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state and outputs.
- `start`  in  1  word valid; accepted when `start && ready` at a clock edge.
- `data_in`  in  WIDTH  word to scan; sampled only at acceptance.
- `abort`  in  1  cancels a scan in progress; ignored in IDLE.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse; results valid and updated.
- `match_count`  out  CW  number of matches in the last completed word.
- `match_any`  out  1  `match_count != 0`.
- `first_pos`  out  PW  `data_in` bit index where the first match completed; 0 if there was no match.
- `match_mask`  out  WIDTH  bit i set when a match completed on `data_in[i]`.
- `total_count`  out  TOTAL_W  sum of `match_count` over all completed words; saturates at all-ones.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT on accept.
  - SHIFT → DONE after WIDTH shift cycles.
  - SHIFT → IDLE on `abort`.
  - DONE → IDLE unconditionally.
- On accept:
  - Load `data_in` into the shift register.
  - Clear the bit counter, the working count, the working mask and the first-found flag.
- Detector connections:
  - The detector's `w` = shift register MSB during SHIFT, 0 otherwise.
  - The detector's reset = `reset | (state != SHIFT)`.
  - The detector is therefore held in its no-prefix state outside SHIFT, and every word is scanned fresh. Patterns never span words.
- Each SHIFT cycle k (k = 0..WIDTH-1) presents `data_in[WIDTH-1-k]` on `w`. At the closing edge, if `z` = 1:
  - Increment the working count.
  - Set the working mask bit `WIDTH-1-k`.
  - If no match has been recorded yet in this word, record `WIDTH-1-k` as the first position.
  - After that edge the register shifts left by one.
- Matching is non-overlapping, as defined by the detector: after a match, the detector returns to its no-prefix state.
- On entry to DONE:
  - Copy the working count, mask and first position to the outputs.
  - Update `match_any`.
  - Set `total_count` to `min(total + count, 2^TOTAL_W - 1)`.
- Result outputs hold between DONE entries.
- Abort during SHIFT:
  - Go straight to IDLE.
  - No `done` pulse.
  - Outputs and `total_count` are unchanged.
  - The partial work is discarded.
- `start` outside IDLE is ignored, with no queuing.
- `abort` and the last SHIFT edge together: abort wins; no `done`, no update.
- Reset at any time, including mid-scan:
  - Next state IDLE.
  - `ready` = 1, `done` = 0.
  - `match_count`, `match_any`, `first_pos`, `match_mask` and `total_count` all 0.

## Timing
- Accept at edge E0: SHIFT during cycles 1..WIDTH, with bit k on `w` in cycle k+1.
- DONE (`done` = 1, new results visible) is cycle WIDTH+1.
- `ready` returns in cycle WIDTH+2.
- Earliest next accept is the edge ending cycle WIDTH+2.
- Throughput: one word per WIDTH+2 cycles.
- `z` is combinational (Mealy) and is sampled only at SHIFT edges. No other combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared constants header holds:
  - state encodings (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2);
  - the default WIDTH and TOTAL_W.
- One sub-module: an instance of the existing `fsm_sequence` detector. Its reset state must be the no-prefix state; the bench checks this.
- Shift register, bit counter, working accumulators and output registers live in `seq_scan_controller`.

## Test plan
- Reset, then `data_in` = 8'hDD:
  - `done` in cycle 9;
  - `match_count` = 2, `match_mask` = 8'b0001_0001, `first_pos` = 4;
  - `total_count` = 2.
- `data_in` = 8'hDA (1101_1010), checking non-overlap:
  - `match_count` = 1, `match_mask` = 8'b0001_0000, `first_pos` = 4.
- `data_in` = 8'h68:
  - `match_count` = 1, `match_mask` = 8'h08, `first_pos` = 3.
- `data_in` = 8'hFF, then 8'h00: each gives `match_count` = 0, `match_any` = 0, `first_pos` = 0, with the total unchanged.
- Abort in cycle 5 of a scan of 8'hDD:
  - no `done`, `ready` = 1 in the next cycle, previous outputs held;
  - an immediately following 8'hDD scan yields 2.
- Mid-operation and saturation:
  - `start` asserted during SHIFT is ignored.
  - Reset asserted in SHIFT clears all outputs and `total_count` next cycle.
  - With TOTAL_W = 2, three 8'hDD words give totals 2, 3, 3.

Source files
------------

// File: rtl/seq_scan_controller_pkg.sv
// Shared types and defaults for the word-level 1-1-0-1 scan controller
// and its bit-serial detector.
package seq_scan_controller_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } scan_state_t;

    // Detector prefix states: how much of 1-1-0-1 has been seen so far
    typedef enum logic [1:0] {
        S_NONE = 2'd0,
        S_1    = 2'd1,
        S_11   = 2'd2,
        S_110  = 2'd3
    } det_state_t;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_TOTAL_W = 16;

endpackage

// File: rtl/seq_scan_controller_if.sv
// Word handshake and result bus between a parallel producer and the
// scan controller.
interface seq_scan_controller_if
    import seq_scan_controller_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TOTAL_W = DEFAULT_TOTAL_W
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(WIDTH);

    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic               abort;
    logic               ready;
    logic               done;
    logic [CW-1:0]      match_count;
    logic               match_any;
    logic [PW-1:0]      first_pos;
    logic [WIDTH-1:0]   match_mask;
    logic [TOTAL_W-1:0] total_count;

    modport master (
        output start, data_in, abort,
        input  ready, done, match_count, match_any, first_pos, match_mask, total_count
    );

    modport slave (
        input  start, data_in, abort,
        output ready, done, match_count, match_any, first_pos, match_mask, total_count
    );

endinterface

// File: rtl/seq_scan_controller_fsm_sequence.sv
// Serial 1-1-0-1 detector, Mealy output, non-overlapping: every match
// returns the machine to the no-prefix state.
module fsm_sequence
    import seq_scan_controller_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic w,
    output logic z
);
    det_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_NONE;
        end else begin
            case (state)
                S_NONE:  state <= w ? S_1  : S_NONE;
                S_1:     state <= w ? S_11 : S_NONE;
                S_11:    state <= w ? S_11 : S_110;
                // "1101" (match) and "1100" both leave no usable prefix
                S_110:   state <= S_NONE;
                default: state <= S_NONE;
            endcase
        end
    end

    assign z = (state == S_110) && w;

endmodule

// File: rtl/seq_scan_controller.sv
// Shifts accepted words MSB-first through the 1-1-0-1 detector and
// reports per-word matches plus a saturating running total.
module seq_scan_controller
    import seq_scan_controller_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int TOTAL_W = DEFAULT_TOTAL_W
)(
    input  logic                  clock,
    input  logic                  reset,
    seq_scan_controller_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(WIDTH);
    localparam int SW = ((TOTAL_W > CW) ? TOTAL_W : CW) + 1;
    localparam logic [SW-1:0] TMAX = (SW'(1) << TOTAL_W) - SW'(1);
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    scan_state_t      state;
    logic [WIDTH-1:0] shreg;
    logic [PW-1:0]    bit_cnt;
    logic [CW-1:0]    work_cnt;
    logic [WIDTH-1:0] work_mask;
    logic [PW-1:0]    work_first;
    logic             found;

    logic             det_w, det_rst, z;
    logic [PW-1:0]    pos;
    logic [CW-1:0]    cnt_nx;
    logic [WIDTH-1:0] mask_nx;
    logic [PW-1:0]    first_nx;
    logic [SW-1:0]    sum;

    assign det_w   = (state == SHIFT) ? shreg[WIDTH-1] : 1'b0;
    assign det_rst = reset | (state != SHIFT);

    fsm_sequence u_det (
        .clk   (clock),
        .reset (det_rst),
        .w     (det_w),
        .z     (z)
    );

    // Accumulators as they stand after the current edge, so the final
    // SHIFT edge can publish results including its own match.
    always_comb begin
        pos      = LAST - bit_cnt;
        cnt_nx   = work_cnt + CW'(z);
        mask_nx  = work_mask | (z ? (WIDTH'(1) << pos) : '0);
        first_nx = (z && !found) ? pos : work_first;
        sum      = SW'(bus.total_count) + SW'(cnt_nx);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            work_cnt        <= '0;
            work_mask       <= '0;
            work_first      <= '0;
            found           <= 1'b0;
            bus.ready       <= 1'b1;
            bus.done        <= 1'b0;
            bus.match_count <= '0;
            bus.match_any   <= 1'b0;
            bus.first_pos   <= '0;
            bus.match_mask  <= '0;
            bus.total_count <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= SHIFT;
                        bus.ready  <= 1'b0;
                        shreg      <= bus.data_in;
                        bit_cnt    <= '0;
                        work_cnt   <= '0;
                        work_mask  <= '0;
                        work_first <= '0;
                        found      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        state     <= IDLE;
                        bus.ready <= 1'b1;
                    end else begin
                        shreg      <= shreg << 1;
                        bit_cnt    <= bit_cnt + PW'(1);
                        work_cnt   <= cnt_nx;
                        work_mask  <= mask_nx;
                        work_first <= first_nx;
                        found      <= found | z;
                        if (bit_cnt == LAST) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.match_count <= cnt_nx;
                            bus.match_any   <= (cnt_nx != '0);
                            bus.first_pos   <= first_nx;
                            bus.match_mask  <= mask_nx;
                            bus.total_count <= (sum > TMAX) ? '1 : sum[TOTAL_W-1:0];
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    bus.ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
